// File: rtl/hazard_pkg.sv
// Shared types for the RAW interlock / forwarding unit: forwarding tap and
// retire port bundles, plus the architectural register file geometry.
package hazard_pkg;

    localparam int HZ_XLEN = 64;
    localparam int HZ_NREG = 32;
    localparam int HZ_RW   = 5;

    typedef logic [HZ_RW-1:0] hz_reg_t;

    typedef struct packed {
        logic               valid;
        hz_reg_t            rd;
        logic               ready;
        logic [HZ_XLEN-1:0] data;
    } hz_tap_t;

    typedef struct packed {
        logic    valid;
        hz_reg_t rd;
    } hz_ret_t;

endpackage

// File: rtl/hazard_src_mux.sv
// Resolves one source operand: x0, youngest matching forwarding tap,
// pending long-latency producer, or regfile read data.
module hazard_src_mux
    import hazard_pkg::*;
#(
    parameter int XLEN = HZ_XLEN,
    parameter int NTAP = 3
) (
    input  logic [HZ_RW-1:0]      rs,
    input  logic [XLEN-1:0]       q,
    input  logic                  pending,
    input  hz_tap_t [NTAP-1:0]    taps,
    output logic [XLEN-1:0]       data,
    output logic                  stall
);

    logic            hit;
    logic            hit_ready;
    logic [XLEN-1:0] hit_data;

    // Walk oldest to youngest so the youngest match (index 0) overwrites older ones.
    always_comb begin
        hit       = 1'b0;
        hit_ready = 1'b0;
        hit_data  = '0;
        for (int k = NTAP - 1; k >= 0; k--) begin
            if (taps[k].valid && taps[k].rd == rs) begin
                hit       = 1'b1;
                hit_ready = taps[k].ready;
                hit_data  = taps[k].data[XLEN-1:0];
            end
        end
    end

    always_comb begin
        data  = q;
        stall = 1'b0;
        if (rs == '0) begin
            data = '0;
        end else if (hit) begin
            data  = hit_data;
            stall = !hit_ready;
        end else if (pending) begin
            stall = 1'b1;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// RAW interlock and forwarding unit: per-register pending-write scoreboard,
// per-source forwarding muxes, stall generation and a stalled-cycle counter.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int XLEN    = HZ_XLEN,
    parameter int NREG    = HZ_NREG,
    parameter int NSRC    = 2,
    parameter int NTAP    = 3,
    parameter int NRET    = 2,
    parameter int MAXPEND = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NSRC*5-1:0]      src_rs,
    input  logic [NSRC*XLEN-1:0]   src_q,
    output logic [NSRC*XLEN-1:0]   src_data,
    input  logic                   issue_fire,
    input  logic                   issue_wen,
    input  logic [4:0]             issue_rd,
    input  logic [NTAP-1:0]        tap_valid,
    input  logic [NTAP*5-1:0]      tap_rd,
    input  logic [NTAP-1:0]        tap_ready,
    input  logic [NTAP*XLEN-1:0]   tap_data,
    input  logic [NRET-1:0]        ret_valid,
    input  logic [NRET*5-1:0]      ret_rd,
    output logic                   stall,
    output logic [31:0]            stall_cycles,
    output logic                   sb_error
);

    localparam int             CW       = $clog2(MAXPEND + 1);
    localparam logic [CW-1:0]  PEND_MAX = CW'(MAXPEND);

    logic [CW-1:0]      pend     [NREG];
    logic [CW-1:0]      pend_nxt [NREG];
    hz_tap_t [NTAP-1:0] taps;
    hz_ret_t [NRET-1:0] rets;
    logic [NSRC-1:0]    src_stall;
    logic               issue_stall;
    logic               issue_err;
    logic               count_err;

    always_comb begin
        for (int k = 0; k < NTAP; k++) begin
            taps[k].valid = tap_valid[k];
            taps[k].rd    = tap_rd[k*5 +: 5];
            taps[k].ready = tap_ready[k];
            taps[k].data  = HZ_XLEN'(tap_data[k*XLEN +: XLEN]);
        end
        for (int p = 0; p < NRET; p++) begin
            rets[p].valid = ret_valid[p];
            rets[p].rd    = ret_rd[p*5 +: 5];
        end
    end

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        logic [4:0] rs;
        assign rs = src_rs[i*5 +: 5];

        hazard_src_mux #(
            .XLEN (XLEN),
            .NTAP (NTAP)
        ) u_mux (
            .rs      (rs),
            .q       (src_q[i*XLEN +: XLEN]),
            .pending (pend[rs] != '0),
            .taps    (taps),
            .data    (src_data[i*XLEN +: XLEN]),
            .stall   (src_stall[i])
        );
    end

    assign issue_stall = issue_wen && (issue_rd != '0) && (pend[issue_rd] == PEND_MAX);
    assign stall       = (|src_stall) || issue_stall;
    assign issue_err   = issue_fire && stall;

    // Net increment/decrement per register; several retire ports may hit the same rd.
    always_comb begin
        int inc;
        int dec;
        int sum;
        inc         = 0;
        dec         = 0;
        sum         = 0;
        count_err   = 1'b0;
        pend_nxt[0] = '0;
        for (int r = 1; r < NREG; r++) begin
            inc = (issue_fire && issue_wen && issue_rd == HZ_RW'(r)) ? 1 : 0;
            dec = 0;
            for (int p = 0; p < NRET; p++) begin
                if (rets[p].valid && rets[p].rd == HZ_RW'(r)) begin
                    dec = dec + 1;
                end
            end
            sum = int'(pend[r]) + inc - dec;
            if (sum > MAXPEND) begin
                pend_nxt[r] = PEND_MAX;
                count_err   = 1'b1;
            end else if (sum < 0) begin
                pend_nxt[r] = '0;
                count_err   = 1'b1;
            end else begin
                pend_nxt[r] = CW'(sum);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                pend[r] <= '0;
            end
            stall_cycles <= '0;
            sb_error     <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                pend[r] <= pend_nxt[r];
            end
            if (stall && stall_cycles != '1) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (count_err || issue_err) begin
                sb_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: forwarding priority, long-latency stalls,
// scoreboard saturation/underflow, x0 handling and mid-stall reset.
module tb_hazard_unit;

    localparam int XLEN = 64;
    localparam int NSRC = 2;
    localparam int NTAP = 3;
    localparam int NRET = 2;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NSRC*5-1:0]     src_rs;
    logic [NSRC*XLEN-1:0]  src_q;
    logic [NSRC*XLEN-1:0]  src_data;
    logic                  issue_fire;
    logic                  issue_wen;
    logic [4:0]            issue_rd;
    logic [NTAP-1:0]       tap_valid;
    logic [NTAP*5-1:0]     tap_rd;
    logic [NTAP-1:0]       tap_ready;
    logic [NTAP*XLEN-1:0]  tap_data;
    logic [NRET-1:0]       ret_valid;
    logic [NRET*5-1:0]     ret_rd;
    logic                  stall;
    logic [31:0]           stall_cycles;
    logic                  sb_error;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    hazard_unit dut (
        .clk          (clk),
        .reset        (reset),
        .src_rs       (src_rs),
        .src_q        (src_q),
        .src_data     (src_data),
        .issue_fire   (issue_fire),
        .issue_wen    (issue_wen),
        .issue_rd     (issue_rd),
        .tap_valid    (tap_valid),
        .tap_rd       (tap_rd),
        .tap_ready    (tap_ready),
        .tap_data     (tap_data),
        .ret_valid    (ret_valid),
        .ret_rd       (ret_rd),
        .stall        (stall),
        .stall_cycles (stall_cycles),
        .sb_error     (sb_error)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        issue_fire = 1'b0;
        issue_wen  = 1'b0;
        issue_rd   = '0;
        tap_valid  = '0;
        tap_rd     = '0;
        tap_ready  = '0;
        tap_data   = '0;
        ret_valid  = '0;
        ret_rd     = '0;
    endtask

    task automatic applyStimulus(input logic [4:0] rs0, input logic [4:0] rs1,
                                 input logic [63:0] q0, input logic [63:0] q1);
        src_rs = {rs1, rs0};
        src_q  = {q1, q0};
    endtask

    initial begin
        logic [1:0] pend_or;
        reset = 1'b1;
        idle();
        applyStimulus(5'd0, 5'd0, 64'd0, 64'd0);
        repeat (2) @(posedge clk);

        // Reset state and plain regfile pass-through
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(5'd5, 5'd6, 64'd11, 64'd22);
        #1;
        checkOutput("t1_data0", src_data[63:0], 64'd11);
        checkOutput("t1_data1", src_data[127:64], 64'd22);
        checkOutput("t1_stall", {63'd0, stall}, 64'd0);
        checkOutput("t1_cycles", {32'd0, stall_cycles}, 64'd0);
        checkOutput("t1_err", {63'd0, sb_error}, 64'd0);
        pend_or = '0;
        for (int r = 0; r < 32; r++) pend_or = pend_or | dut.pend[r];
        checkOutput("t1_pend_clear", {62'd0, pend_or}, 64'd0);

        // Youngest tap wins over older tap on the same rd
        @(negedge clk);
        tap_valid = 3'b101;
        tap_ready = 3'b101;
        tap_rd    = {5'd5, 5'd0, 5'd5};
        tap_data  = {64'hBB, 64'h0, 64'hAA};
        #1;
        checkOutput("t2_young_data", src_data[63:0], 64'hAA);
        checkOutput("t2_young_stall", {63'd0, stall}, 64'd0);
        checkOutput("t2_other_src", src_data[127:64], 64'd22);
        tap_ready = 3'b100;
        #1;
        checkOutput("t2_young_notready", {63'd0, stall}, 64'd1);
        idle();

        // Long-latency producer: issue rd=7, retire in 4th stalled cycle
        @(negedge clk);
        applyStimulus(5'd0, 5'd0, 64'd0, 64'd0);
        issue_fire = 1'b1;
        issue_wen  = 1'b1;
        issue_rd   = 5'd7;
        #1;
        checkOutput("t3_issue_nostall", {63'd0, stall}, 64'd0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            idle();
            applyStimulus(5'd7, 5'd0, 64'h77, 64'd0);
            if (c == 4) begin
                ret_valid = 2'b01;
                ret_rd    = {5'd0, 5'd7};
            end
            #1;
            checkOutput($sformatf("t3_stall_c%0d", c), {63'd0, stall}, 64'd1);
        end
        @(negedge clk);
        idle();
        #1;
        checkOutput("t3_unstall", {63'd0, stall}, 64'd0);
        checkOutput("t3_data", src_data[63:0], 64'h77);
        checkOutput("t3_cycles", {32'd0, stall_cycles}, 64'd4);

        // Saturation at MAXPEND: three issues to rd=3, then issue-side stall
        applyStimulus(5'd0, 5'd0, 64'd0, 64'd0);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            issue_fire = 1'b1;
            issue_wen  = 1'b1;
            issue_rd   = 5'd3;
            #1;
            checkOutput($sformatf("t4_issue%0d_nostall", n), {63'd0, stall}, 64'd0);
        end
        @(negedge clk);
        issue_fire = 1'b0;
        #1;
        checkOutput("t4_full_stall", {63'd0, stall}, 64'd1);
        issue_fire = 1'b1;
        ret_valid  = 2'b01;
        ret_rd     = {5'd0, 5'd3};
        @(negedge clk);
        idle();
        #1;
        checkOutput("t4_pend_net", {62'd0, dut.pend[3]}, 64'd3);
        checkOutput("t4_fire_in_stall_err", {63'd0, sb_error}, 64'd1);
        applyStimulus(5'd3, 5'd0, 64'd0, 64'd0);
        #1;
        checkOutput("t4_src_pending", {63'd0, stall}, 64'd1);

        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(5'd0, 5'd0, 64'd0, 64'd0);
        #1;
        checkOutput("t4_rst_err", {63'd0, sb_error}, 64'd0);
        checkOutput("t4_rst_cycles", {32'd0, stall_cycles}, 64'd0);

        // Squash: two ports retire rd=9 together, then an extra retire underflows
        @(negedge clk);
        issue_fire = 1'b1;
        issue_wen  = 1'b1;
        issue_rd   = 5'd9;
        @(negedge clk);
        ret_valid  = 2'b10;
        ret_rd     = {5'd0, 5'd0};
        @(negedge clk);
        idle();
        #1;
        checkOutput("t5_pend2", {62'd0, dut.pend[9]}, 64'd2);
        ret_valid = 2'b11;
        ret_rd    = {5'd9, 5'd9};
        @(negedge clk);
        idle();
        applyStimulus(5'd9, 5'd0, 64'h99, 64'd0);
        #1;
        checkOutput("t5_pend0", {62'd0, dut.pend[9]}, 64'd0);
        checkOutput("t5_no_err", {63'd0, sb_error}, 64'd0);
        checkOutput("t5_src_free", src_data[63:0], 64'h99);
        ret_valid = 2'b01;
        ret_rd    = {5'd0, 5'd9};
        @(negedge clk);
        idle();
        #1;
        checkOutput("t5_underflow_err", {63'd0, sb_error}, 64'd1);
        checkOutput("t5_pend_sat0", {62'd0, dut.pend[9]}, 64'd0);

        // x0 never forwards or stalls, even with a valid tap naming rd=0
        @(negedge clk);
        applyStimulus(5'd0, 5'd0, 64'h55, 64'h66);
        tap_valid = 3'b001;
        tap_ready = 3'b000;
        tap_rd    = '0;
        tap_data  = {64'h0, 64'h0, 64'hCC};
        #1;
        checkOutput("t6_x0_data0", src_data[63:0], 64'd0);
        checkOutput("t6_x0_data1", src_data[127:64], 64'd0);
        checkOutput("t6_x0_stall", {63'd0, stall}, 64'd0);

        // Reset mid-stall clears pending state and drops a same-cycle retire
        idle();
        applyStimulus(5'd0, 5'd0, 64'd0, 64'd0);
        issue_fire = 1'b1;
        issue_wen  = 1'b1;
        issue_rd   = 5'd12;
        @(negedge clk);
        idle();
        applyStimulus(5'd12, 5'd0, 64'h1212, 64'd0);
        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("t6_stall_before_rst", {63'd0, stall}, 64'd1);
        checkOutput("t6_cycles_before_rst", {32'd0, stall_cycles}, 64'd2);
        reset     = 1'b1;
        ret_valid = 2'b01;
        ret_rd    = {5'd0, 5'd12};
        @(negedge clk);
        reset = 1'b0;
        idle();
        #1;
        checkOutput("t6_rst_stall", {63'd0, stall}, 64'd0);
        checkOutput("t6_rst_cycles", {32'd0, stall_cycles}, 64'd0);
        checkOutput("t6_rst_data", src_data[63:0], 64'h1212);
        @(negedge clk);
        #1;
        checkOutput("t6_rst_ret_dropped", {63'd0, sb_error}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
